// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory handshake, redirect/stall
// inputs from downstream, and the head entry presented to the FD latch.
interface fetch_queue_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_stall;
  logic        fd_valid;
  logic [15:0] fd_instr;
  logic [15:0] fd_pc;
  logic [15:0] fd_pc_plus2;
  logic        halted;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_done,
    input  redirect_valid,
    input  redirect_pc,
    input  dec_stall,
    output fd_valid,
    output fd_instr,
    output fd_pc,
    output fd_pc_plus2,
    output halted
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_done,
    output redirect_valid,
    output redirect_pc,
    output dec_stall,
    input  fd_valid,
    input  fd_instr,
    input  fd_pc,
    input  fd_pc_plus2,
    input  halted
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage front end: one-outstanding imem requester, sequential PC,
// and a small FIFO of {instr, pc} feeding the FD pipeline latch.
module fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HALT
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } fq_entry_t;

  state_t        state;
  logic [15:0]   pc;
  logic [15:0]   req_addr;
  logic          req;
  logic          squash;
  logic          halt_q;

  fq_entry_t     mem [DEPTH];
  fq_entry_t     head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_ap;

  logic          fd_valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic          is_halt;

  assign head     = mem[rd_ptr];
  assign fd_valid = count != '0;
  assign pop      = fd_valid & ~bus.dec_stall;
  assign count_ap = count - CW'(pop);
  assign is_halt  = bus.imem_rdata[15:11] == 5'b00000;

  assign issue = (state == FETCH)
               & ~bus.redirect_valid
               & (count_ap < FULL);

  assign push = (state == WAIT)
              & bus.imem_done
              & ~squash
              & ~bus.redirect_valid;

  // Request/PC sequencer; a redirect always wins over the normal flow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      req      <= 1'b0;
      squash   <= 1'b0;
      halt_q   <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc     <= bus.redirect_pc;
      halt_q <= 1'b0;
      if (state == WAIT && !bus.imem_done) begin
        state  <= WAIT;
        squash <= 1'b1;
      end else begin
        state  <= FETCH;
        req    <= 1'b0;
        squash <= 1'b0;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (issue) begin
            req      <= 1'b1;
            req_addr <= pc;
            pc       <= pc + 16'd2;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_done) begin
            req    <= 1'b0;
            squash <= 1'b0;
            if (!squash && is_halt) begin
              state  <= HALT;
              halt_q <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          req <= 1'b0;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  // Entry FIFO; a redirect flushes it outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr].instr <= bus.imem_rdata;
        mem[wr_ptr].pc    <= req_addr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = req_addr;
  assign bus.fd_valid    = fd_valid;
  assign bus.fd_instr    = fd_valid ? head.instr : NOP_INSTR;
  assign bus.fd_pc       = head.pc;
  assign bus.fd_pc_plus2 = head.pc + 16'd2;
  assign bus.halted      = halt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory responder with variable latency and a
// queue-based reference model of the fetched instruction stream.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(16'h0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] halt_addr = 16'hFFFF;
  int lat = 1;
  int wcnt = 0;
  bit rand_lat = 1'b0;
  bit force_done = 1'b0;

  logic [15:0] m_q[$];
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  bit m_req;
  bit m_squash;
  bit m_halted;

  function automatic logic [15:0] word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return 16'h8000 | ((a ^ 16'h5A5A) & 16'h7FFF);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc = 16'h0000;
    m_addr = 16'h0000;
    m_req = 1'b0;
    m_squash = 1'b0;
    m_halted = 1'b0;
    wcnt = 0;
  endtask

  // One clock: memory response, model update, then advance to next negedge.
  task automatic cycle();
    logic d;
    logic pop;
    logic [15:0] w;
    d = 1'b0;
    if (force_done) begin
      d = 1'b1;
    end else if (bus.imem_req) begin
      if (wcnt == 0 && rand_lat) lat = $urandom_range(1, 4);
      wcnt++;
      if (wcnt >= lat) begin
        d = 1'b1;
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
    bus.imem_done = d;
    if (force_done) bus.imem_rdata = 16'h1111;
    else bus.imem_rdata = d ? word(bus.imem_addr) : 16'hDEAD;

    pop = (m_q.size() != 0) && !bus.dec_stall;
    if (bus.redirect_valid) begin
      m_q.delete();
      m_pc = bus.redirect_pc;
      m_halted = 1'b0;
      if (m_req && !d) begin
        m_squash = 1'b1;
      end else begin
        m_req = 1'b0;
        m_squash = 1'b0;
      end
    end else if (m_req) begin
      if (pop) void'(m_q.pop_front());
      if (d) begin
        if (!m_squash) begin
          m_q.push_back(m_addr);
          w = word(m_addr);
          if (w[15:11] == 5'b00000) m_halted = 1'b1;
        end
        m_req = 1'b0;
        m_squash = 1'b0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_halted && m_q.size() < DEPTH) begin
        m_req = 1'b1;
        m_addr = m_pc;
        m_pc = m_pc + 16'd2;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_done = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.dec_stall = 1'b0;
    force_done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks += 6;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %b want 0", bus.imem_req);
    end
    if (bus.fd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", bus.fd_valid);
    end
    if (bus.fd_instr !== NOP) begin
      errors++; $display("FAIL reset_instr got %h want %h", bus.fd_instr, NOP);
    end
    if (bus.fd_pc !== 16'h0000) begin
      errors++; $display("FAIL reset_pc got %h want 0000", bus.fd_pc);
    end
    if (bus.fd_pc_plus2 !== 16'h0002) begin
      errors++; $display("FAIL reset_pc2 got %h want 0002", bus.fd_pc_plus2);
    end
    if (bus.halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted got %b want 0", bus.halted);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    logic [15:0] p2;
    do_reset();
    lat = 1;
    rand_lat = 1'b0;
    exp_pc = 16'h0000;
    repeat (16) begin
      cycle();
      checks++;
      if (bus.imem_req !== m_req) begin
        errors++; $display("FAIL stream_req t=%0t got %b want %b", $time, bus.imem_req, m_req);
      end
      if (m_req) begin
        checks++;
        if (bus.imem_addr !== m_addr) begin
          errors++; $display("FAIL stream_addr got %h want %h", bus.imem_addr, m_addr);
        end
      end
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL stream_valid t=%0t got %b want %b", $time, bus.fd_valid, m_q.size() != 0);
      end
      if (bus.fd_valid) begin
        p2 = exp_pc + 16'd2;
        checks++;
        if (bus.fd_pc !== exp_pc || bus.fd_instr !== word(exp_pc) || bus.fd_pc_plus2 !== p2) begin
          errors++;
          $display("FAIL stream_head got %h/%h/%h want %h/%h/%h", bus.fd_pc, bus.fd_instr,
                   bus.fd_pc_plus2, exp_pc, word(exp_pc), p2);
        end
        exp_pc = exp_pc + 16'd2;
      end
    end
    checks++;
    if (exp_pc < 16'h0006) begin
      errors++; $display("FAIL stream_count got %h want >=0006", exp_pc);
    end
  endtask

  task automatic test_stall();
    bus.dec_stall = 1'b1;
    repeat (6) begin
      cycle();
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.fd_pc !== m_q[0])) begin
        errors++; $display("FAIL stall_head got %b/%h want %0d entries", bus.fd_valid, bus.fd_pc, m_q.size());
      end
    end
    checks += 2;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_full_req got %b want 0", bus.imem_req);
    end
    if (bus.fd_valid !== 1'b1) begin
      errors++; $display("FAIL stall_full_valid got %b want 1", bus.fd_valid);
    end
    bus.dec_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 2) begin
        checks++;
        if (bus.fd_valid !== 1'b1) begin
          errors++; $display("FAIL drain_gap i=%0d got %b want 1", i, bus.fd_valid);
        end
      end
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.fd_pc !== m_q[0])) begin
        errors++; $display("FAIL drain_head got %b/%h want %0d entries", bus.fd_valid, bus.fd_pc, m_q.size());
      end
    end
  endtask

  task automatic test_latency();
    int run;
    do_reset();
    lat = 3;
    run = 0;
    repeat (24) begin
      cycle();
      checks++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_addr)) begin
        errors++; $display("FAIL lat_req got %b/%h want %b/%h", bus.imem_req, bus.imem_addr, m_req, m_addr);
      end
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.fd_pc !== m_q[0])) begin
        errors++; $display("FAIL lat_head got %b/%h want %0d entries", bus.fd_valid, bus.fd_pc, m_q.size());
      end
      if (bus.imem_req) begin
        run++;
      end else if (run != 0) begin
        checks++;
        if (run != 3) begin
          errors++; $display("FAIL lat_hold got %0d cycles want 3", run);
        end
        run = 0;
      end
    end
  endtask

  task automatic test_redirect();
    bit found;
    bit seen4;
    do_reset();
    lat = 3;
    found = 1'b0;
    seen4 = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      bus.dec_stall = seen4;
      cycle();
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0) || bus.imem_req !== m_req) begin
        errors++; $display("FAIL redir_pre got %b/%b want %b/%b", bus.fd_valid, bus.imem_req, m_q.size() != 0, m_req);
      end
      if (bus.imem_req && bus.imem_addr == 16'h0004) seen4 = 1'b1;
      if (bus.imem_req && bus.imem_addr == 16'h0006) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL redir_wait got no request to 0006 want one");
    end else begin
      checks++;
      if (bus.fd_valid !== 1'b1) begin
        errors++; $display("FAIL redir_fifo got %b want 1", bus.fd_valid);
      end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0040;
    bus.dec_stall = 1'b0;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.fd_valid !== 1'b0) begin
      errors++; $display("FAIL redir_flush got %b want 0", bus.fd_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      checks++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_addr)) begin
        errors++; $display("FAIL redir_req got %b/%h want %b/%h", bus.imem_req, bus.imem_addr, m_req, m_addr);
      end
      if (bus.fd_valid) begin
        found = 1'b1;
        checks++;
        if (bus.fd_pc !== 16'h0040 || bus.fd_instr !== word(16'h0040)) begin
          errors++; $display("FAIL redir_target got %h/%h want 0040/%h", bus.fd_pc, bus.fd_instr, word(16'h0040));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL redir_timeout got no fd_valid want 0040");
    end
  endtask

  task automatic test_halt();
    bit found;
    bit seen_halt;
    do_reset();
    lat = 1;
    halt_addr = 16'h000A;
    found = 1'b0;
    seen_halt = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      checks++;
      if (bus.halted !== m_halted || bus.imem_req !== m_req) begin
        errors++; $display("FAIL halt_pre got %b/%b want %b/%b", bus.halted, bus.imem_req, m_halted, m_req);
      end
      if (bus.halted) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL halt_timeout got halted=0 want 1");
    end
    repeat (6) begin
      if (bus.fd_valid && bus.fd_pc == 16'h000A && bus.fd_instr == 16'h0000) seen_halt = 1'b1;
      cycle();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1) begin
        errors++; $display("FAIL halt_idle got req=%b halted=%b want 0/1", bus.imem_req, bus.halted);
      end
    end
    checks++;
    if (!seen_halt) begin
      errors++; $display("FAIL halt_word got not presented want 000A/0000");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0020;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++; $display("FAIL halt_clear got %b want 0", bus.halted);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (bus.fd_valid) begin
        found = 1'b1;
        checks++;
        if (bus.fd_pc !== 16'h0020) begin
          errors++; $display("FAIL halt_resume got %h want 0020", bus.fd_pc);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL halt_resume_timeout got no fd_valid want 0020");
    end
    halt_addr = 16'hFFFF;
  endtask

  task automatic test_edges();
    logic [15:0] prev;
    bit wrapped;
    bit got_req;
    do_reset();
    lat = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'hFFFC;
    cycle();
    bus.redirect_valid = 1'b0;
    prev = 16'h1234;
    wrapped = 1'b0;
    repeat (16) begin
      cycle();
      checks++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_addr)) begin
        errors++; $display("FAIL wrap_req got %b/%h want %b/%h", bus.imem_req, bus.imem_addr, m_req, m_addr);
      end
      if (bus.fd_valid) begin
        if (prev == 16'hFFFE) begin
          wrapped = 1'b1;
          checks++;
          if (bus.fd_pc !== 16'h0000 || bus.fd_instr !== word(16'h0000)) begin
            errors++; $display("FAIL wrap_pc got %h/%h want 0000/%h", bus.fd_pc, bus.fd_instr, word(16'h0000));
          end
        end
        prev = bus.fd_pc;
      end
    end
    checks++;
    if (!wrapped) begin
      errors++; $display("FAIL wrap_seen got no FFFE->0000 want one");
    end
    lat = 3;
    got_req = 1'b0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      cycle();
      if (bus.imem_req) got_req = 1'b1;
    end
    checks++;
    if (!got_req) begin
      errors++; $display("FAIL rst_wait got no request want one");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.fd_valid !== 1'b0 || bus.fd_instr !== NOP || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got %b/%b/%h/%b want 0/0/%h/0", bus.imem_req, bus.fd_valid, bus.fd_instr, bus.halted, NOP);
    end
    @(negedge clk);
    model_reset();
    bus.imem_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    force_done = 1'b1;
    cycle();
    force_done = 1'b0;
    checks++;
    if (bus.fd_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++; $display("FAIL stale_done got %b/%b/%h want 0/1/0000", bus.fd_valid, bus.imem_req, bus.imem_addr);
    end
    repeat (10) begin
      cycle();
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.fd_instr !== word(m_q[0]))) begin
        errors++; $display("FAIL stale_head got %b/%h want %0d entries", bus.fd_valid, bus.fd_instr, m_q.size());
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] p2;
    do_reset();
    rand_lat = 1'b1;
    halt_addr = 16'h0010;
    repeat (600) begin
      bus.dec_stall = $urandom_range(0, 99) < 30;
      bus.redirect_valid = $urandom_range(0, 99) < 6;
      bus.redirect_pc = 16'($urandom_range(0, 31)) << 1;
      cycle();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.imem_req !== m_req || (m_req && bus.imem_addr !== m_addr)) begin
        errors++; $display("FAIL rnd_req t=%0t got %b/%h want %b/%h", $time, bus.imem_req, bus.imem_addr, m_req, m_addr);
      end
      checks++;
      if (bus.fd_valid !== (m_q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid t=%0t got %b want %b", $time, bus.fd_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        p2 = m_q[0] + 16'd2;
        checks++;
        if (bus.fd_pc !== m_q[0] || bus.fd_instr !== word(m_q[0]) || bus.fd_pc_plus2 !== p2) begin
          errors++;
          $display("FAIL rnd_head t=%0t got %h/%h/%h want %h/%h/%h", $time, bus.fd_pc, bus.fd_instr,
                   bus.fd_pc_plus2, m_q[0], word(m_q[0]), p2);
        end
      end else begin
        checks++;
        if (bus.fd_instr !== NOP) begin
          errors++; $display("FAIL rnd_nop t=%0t got %h want %h", $time, bus.fd_instr, NOP);
        end
      end
      checks++;
      if (bus.halted !== m_halted) begin
        errors++; $display("FAIL rnd_halted t=%0t got %b want %b", $time, bus.halted, m_halted);
      end
    end
    rand_lat = 1'b0;
    halt_addr = 16'hFFFF;
    bus.dec_stall = 1'b0;
  endtask

  initial begin
    bus.imem_done = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.dec_stall = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_halt();
    test_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
